ccsds_stream_harness: RTL and testbench

- Synthesizable on-chip stimulus/capture harness for ccsds123_top, for board-level regression without a simulator.
- Streams a preloaded image of PIPELINES×D-bit sample words from an external synchronous memory into the compressor input AXI-Stream.
  - Repeats the stream for a programmable number of iterations.
  - Inserts LFSR-driven bubbles on request.
- Signs the compressor output per iteration with a word count and a 32-bit rolling checksum.

---
 rtl/ccsds_harness_pkg.sv | 39 +++
 rtl/ccsds_harness_prefetch.sv | 84 ++++++++
 rtl/ccsds_stream_harness.sv | 233 +++++++++++++++++++++++
 tb/tb_ccsds_stream_harness.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccsds_harness_pkg.sv
// Shared types and helpers for the ccsds123 stream harness.
//   - source FSM state encoding
//   - 16-bit Fibonacci LFSR taps (16,14,13,11) and step function
//   - 32-bit checksum slice fold and rotate-xor update
package ccsds_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2,
        ST_DRAIN  = 2'd3
    } src_state_e;

    // Taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] LFSR_RESET = 16'h0001;

    // Output buses are zero-extended to this width before folding; wider buses are not supported.
    localparam int unsigned FOLD_MAX_BITS = 1024;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // XOR of all 32-bit slices; zero padding slices do not change the result.
    function automatic logic [31:0] cs_fold(input logic [FOLD_MAX_BITS-1:0] data);
        logic [31:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < FOLD_MAX_BITS / 32; i++) begin
            acc = acc ^ data[i*32 +: 32];
        end
        return acc;
    endfunction

    function automatic logic [31:0] cs_update(input logic [31:0] cs, input logic [31:0] fold);
        return {cs[30:0], cs[31]} ^ fold;
    endfunction

endpackage

// File: rtl/ccsds_harness_prefetch.sv
// Two-entry memory-to-AXI-Stream skid FIFO with outstanding-read tracking.
//   fetch_ok_i    addresses remain and the source is streaming
//   present_ok_i  bubble gate: a new beat may be presented next cycle
//   issue_c_o     combinational read issue (memory data returns next cycle)
//   rdata_i       memory read data
//   tdata_o/tvalid_o/tready_i  AXI-Stream master side
//   pop_c_o       combinational handshake indication
module ccsds_harness_prefetch #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              fetch_ok_i,
    input  logic              present_ok_i,
    output logic              issue_c_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] tdata_o,
    output logic              tvalid_o,
    input  logic              tready_i,
    output logic              pop_c_o
);

    logic [1:0]        count_q, count_d;
    logic              rd_pend_q;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              valid_q, valid_d;
    logic              push;

    // Credits count the entry leaving this cycle so back-to-back beats sustain full rate.
    always_comb begin
        pop_c_o   = valid_q & tready_i;
        push      = rd_pend_q;
        issue_c_o = fetch_ok_i &&
                    ((3'(count_q) + 3'(rd_pend_q) - 3'(pop_c_o)) < 3'd2);

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop_c_o})
            2'b10: begin
                if (count_q == 2'd0) head_d = rdata_i;
                else                 tail_d = rdata_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = rdata_i;
                end else begin
                    head_d = tail_q;
                    tail_d = rdata_i;
                end
            end
            default: ;
        endcase

        // A presented beat holds until accepted; a bubble only delays a new beat.
        valid_d = (valid_q && !tready_i) || ((count_d != 2'd0) && present_ok_i);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            count_q   <= '0;
            rd_pend_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            rd_pend_q <= issue_c_o;
            head_q    <= head_d;
            tail_q    <= tail_d;
            valid_q   <= valid_d;
        end
    end

    assign tdata_o  = head_q;
    assign tvalid_o = valid_q;

endmodule

// File: rtl/ccsds_stream_harness.sv
// On-chip stimulus/capture harness for ccsds123_top.
// Streams num_words beats from sample memory into the compressor num_iters times
// (optionally with LFSR bubbles), and signs each compressed image with a word
// count and rolling checksum.
//   start/num_words/num_iters/bubble_en/bubble_seed  run control, sampled at start
//   mem_en/mem_addr/mem_rdata                        sample memory (1-cycle read)
//   in_tdata/in_tvalid/in_tready                     compressor input stream
//   out_tdata/out_tvalid/out_tlast                   compressor output stream
//   busy/done/iter_done/iter_count/res_words/res_checksum  status and results
module ccsds_stream_harness
    import ccsds_harness_pkg::*;
#(
    parameter int unsigned PIPELINES  = 4,
    parameter int unsigned D          = 16,
    parameter int unsigned BUS_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ITER_WIDTH = 8,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  num_words,
    input  logic [ITER_WIDTH-1:0]  num_iters,
    input  logic                   bubble_en,
    input  logic [15:0]            bubble_seed,
    output logic                   mem_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [PIPELINES*D-1:0] mem_rdata,
    output logic [PIPELINES*D-1:0] in_tdata,
    output logic                   in_tvalid,
    input  logic                   in_tready,
    input  logic [BUS_WIDTH-1:0]   out_tdata,
    input  logic                   out_tvalid,
    input  logic                   out_tlast,
    output logic                   busy,
    output logic                   iter_done,
    output logic                   done,
    output logic [ITER_WIDTH-1:0]  iter_count,
    output logic [31:0]            res_words,
    output logic [31:0]            res_checksum
);

    localparam int unsigned DATA_W = PIPELINES * D;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    src_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] words_q, words_d;
    logic [ITER_WIDTH-1:0] iters_q, iters_d;
    logic                  bubble_q, bubble_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] hs_cnt_q, hs_cnt_d;
    logic [ITER_WIDTH-1:0] src_iter_q, src_iter_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  busy_q, done_q, done_d;
    logic                  start_run_c;

    logic                  fetch_ok_c, present_ok_c, issue_c, pop_c;

    logic [31:0]           word_cnt_q, cs_q, res_words_q, res_cs_q;
    logic [ITER_WIDTH-1:0] iter_count_q;
    logic                  iter_done_q;
    logic [31:0]           fold_c, cs_next_c, words_next_c;

    // Bubble LFSR: seeded at start, stepped every streaming cycle.
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == ST_IDLE && start) begin
            lfsr_d = (bubble_seed == 16'h0000) ? LFSR_RESET : bubble_seed;
        end else if (state_q == ST_STREAM) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    assign fetch_ok_c   = (state_q == ST_STREAM) && (addr_q != words_q);
    assign present_ok_c = !bubble_q || (lfsr_d[1:0] == 2'b00);

    ccsds_harness_prefetch #(
        .DATA_W (DATA_W)
    ) u_prefetch (
        .clk          (clk),
        .aresetn      (aresetn),
        .fetch_ok_i   (fetch_ok_c),
        .present_ok_i (present_ok_c),
        .issue_c_o    (issue_c),
        .rdata_i      (mem_rdata),
        .tdata_o      (in_tdata),
        .tvalid_o     (in_tvalid),
        .tready_i     (in_tready),
        .pop_c_o      (pop_c)
    );

    // Source FSM next-state logic.
    always_comb begin
        state_d     = state_q;
        words_d     = words_q;
        iters_d     = iters_q;
        bubble_d    = bubble_q;
        addr_d      = addr_q;
        hs_cnt_d    = hs_cnt_q;
        src_iter_d  = src_iter_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = 1'b0;
        start_run_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_run_c = 1'b1;
                    words_d     = num_words;
                    bubble_d    = bubble_en;
                    addr_d      = '0;
                    hs_cnt_d    = '0;
                    src_iter_d  = '0;
                    // An empty run drains with a zero target so done follows immediately.
                    if (num_words == '0 || num_iters == '0) begin
                        iters_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        iters_d = num_iters;
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (issue_c) addr_d = addr_q + ADDR_WIDTH'(1);
                if (pop_c) begin
                    hs_cnt_d = hs_cnt_q + ADDR_WIDTH'(1);
                    if (hs_cnt_q == words_q - ADDR_WIDTH'(1)) begin
                        state_d    = ST_GAP;
                        gap_cnt_d  = '0;
                        src_iter_d = src_iter_q + ITER_WIDTH'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (src_iter_q == iters_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d  = ST_STREAM;
                        addr_d   = '0;
                        hs_cnt_d = '0;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_DRAIN: begin
                if (iter_count_q >= iters_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            words_q    <= '0;
            iters_q    <= '0;
            bubble_q   <= 1'b0;
            lfsr_q     <= LFSR_RESET;
            addr_q     <= '0;
            hs_cnt_q   <= '0;
            src_iter_q <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            iters_q    <= iters_d;
            bubble_q   <= bubble_d;
            lfsr_q     <= lfsr_d;
            addr_q     <= addr_d;
            hs_cnt_q   <= hs_cnt_d;
            src_iter_q <= src_iter_d;
            gap_cnt_q  <= gap_cnt_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= done_d;
        end
    end

    // Sink signature: running count/checksum per image, latched on tlast.
    assign fold_c       = cs_fold(FOLD_MAX_BITS'(out_tdata));
    assign cs_next_c    = cs_update(cs_q, fold_c);
    assign words_next_c = word_cnt_q + 32'd1;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            word_cnt_q   <= '0;
            cs_q         <= '0;
            res_words_q  <= '0;
            res_cs_q     <= '0;
            iter_count_q <= '0;
            iter_done_q  <= 1'b0;
        end else begin
            iter_done_q <= 1'b0;
            if (start_run_c) begin
                word_cnt_q   <= '0;
                cs_q         <= '0;
                res_words_q  <= '0;
                res_cs_q     <= '0;
                iter_count_q <= '0;
            end else if (busy_q && out_tvalid) begin
                if (out_tlast) begin
                    res_words_q <= words_next_c;
                    res_cs_q    <= cs_next_c;
                    word_cnt_q  <= '0;
                    cs_q        <= '0;
                    iter_done_q <= 1'b1;
                    if (iter_count_q != '1) iter_count_q <= iter_count_q + ITER_WIDTH'(1);
                end else begin
                    word_cnt_q <= words_next_c;
                    cs_q       <= cs_next_c;
                end
            end
        end
    end

    assign mem_en       = issue_c;
    assign mem_addr     = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign iter_done    = iter_done_q;
    assign iter_count   = iter_count_q;
    assign res_words    = res_words_q;
    assign res_checksum = res_cs_q;

endmodule

// File: tb/tb_ccsds_stream_harness.sv
// Self-checking bench for ccsds_stream_harness: source beats/addresses and sink
// signatures are checked against scoreboard queues filled as stimulus is driven.
module tb_ccsds_stream_harness;

    localparam int unsigned PIPELINES  = 4;
    localparam int unsigned D          = 16;
    localparam int unsigned BUS_WIDTH  = 64;
    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned ITER_WIDTH = 8;
    localparam int unsigned GAP_CYCLES = 4;
    localparam int unsigned DW         = PIPELINES * D;

    logic                  clk = 1'b0;
    logic                  aresetn = 1'b0;
    logic                  start = 1'b0;
    logic [ADDR_WIDTH-1:0] num_words = '0;
    logic [ITER_WIDTH-1:0] num_iters = '0;
    logic                  bubble_en = 1'b0;
    logic [15:0]           bubble_seed = '0;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DW-1:0]         mem_rdata = '0;
    logic [DW-1:0]         in_tdata;
    logic                  in_tvalid;
    logic                  in_tready = 1'b1;
    logic [BUS_WIDTH-1:0]  out_tdata = '0;
    logic                  out_tvalid = 1'b0;
    logic                  out_tlast = 1'b0;
    logic                  busy, iter_done, done;
    logic [ITER_WIDTH-1:0] iter_count;
    logic [31:0]           res_words, res_checksum;

    ccsds_stream_harness #(
        .PIPELINES(PIPELINES), .D(D), .BUS_WIDTH(BUS_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .ITER_WIDTH(ITER_WIDTH), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .aresetn(aresetn), .start(start),
        .num_words(num_words), .num_iters(num_iters),
        .bubble_en(bubble_en), .bubble_seed(bubble_seed),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
        .busy(busy), .iter_done(iter_done), .done(done),
        .iter_count(iter_count), .res_words(res_words), .res_checksum(res_checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample memory: word k holds k, data valid one cycle after mem_en.
    always @(posedge clk) if (mem_en) mem_rdata <= DW'(mem_addr);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] words;
        logic [31:0] cs;
        logic [7:0]  cnt;
    } res_t;

    logic [63:0] exp_beat_q[$];
    logic [15:0] exp_addr_q[$];
    res_t        exp_res_q[$];

    bit          mon_on = 1'b0;
    bit          expect_b2b = 1'b0;
    int          run_words = 0;
    int          run_start = 0;
    int          first_valid = -1;
    int          done_cyc = -1;
    int          last_hs = 0;
    int          n_hs = 0, n_mem = 0, n_done = 0, n_iterdone = 0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic [63:0] prev_data = '0;
    logic [7:0]  exp_icnt = '0;

    function automatic logic [31:0] model_cs(input logic [31:0] cs, input logic [63:0] w);
        logic [31:0] f;
        f = w[63:32] ^ w[31:0];
        return ((cs << 1) | (cs >> 31)) ^ f;
    endfunction

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            if (mem_en) begin
                n_mem++;
                if (exp_addr_q.size() == 0) check_val("unexpected_read", 64'(exp_addr_q.size()), 64'd1);
                else check_val("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
            end
            if (prev_valid && !prev_ready) begin
                check_val("hold_valid", 64'(in_tvalid), 64'd1);
                check_val("hold_data", 64'(in_tdata), prev_data);
            end
            if (in_tvalid && first_valid < 0) first_valid = cyc;
            if (in_tvalid && in_tready) begin
                if (run_words != 0 && n_hs != 0 && (n_hs % run_words) == 0)
                    check_val("iter_gap", 64'((cyc - last_hs - 1) >= int'(GAP_CYCLES)), 64'd1);
                else if (expect_b2b && n_hs != 0)
                    check_val("back_to_back", 64'(cyc - last_hs), 64'd1);
                if (exp_beat_q.size() == 0) check_val("unexpected_beat", 64'(exp_beat_q.size()), 64'd1);
                else check_val("in_tdata", 64'(in_tdata), exp_beat_q.pop_front());
                last_hs = cyc;
                n_hs++;
            end
            if (iter_done) begin
                n_iterdone++;
                if (exp_res_q.size() == 0) begin
                    check_val("unexpected_iter_done", 64'(exp_res_q.size()), 64'd1);
                end else begin
                    res_t r;
                    r = exp_res_q.pop_front();
                    check_val("res_words", 64'(res_words), 64'(r.words));
                    check_val("res_checksum", 64'(res_checksum), 64'(r.cs));
                    check_val("iter_count", 64'(iter_count), 64'(r.cnt));
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        prev_valid = in_tvalid;
        prev_ready = in_tready;
        prev_data  = 64'(in_tdata);
    end

    // ready_mode: 0 always ready, 1 stalled on relative cycles 3..5, 2 random.
    task automatic run_case(input string name, input int words, input int iters, input bit bub,
                            input logic [15:0] seed, input int ready_mode, input int npk);
        logic [31:0] wc, cs;
        logic [63:0] w;
        int          pk, ph;
        exp_beat_q.delete();
        exp_addr_q.delete();
        exp_res_q.delete();
        if (words != 0) begin
            for (int it = 0; it < iters; it++) begin
                for (int k = 0; k < words; k++) begin
                    exp_beat_q.push_back(64'(k));
                    exp_addr_q.push_back(16'(k));
                end
            end
        end
        n_hs = 0; n_mem = 0; n_done = 0; n_iterdone = 0;
        first_valid = -1; done_cyc = -1;
        run_words  = words;
        expect_b2b = (ready_mode == 0) && !bub;
        exp_icnt   = '0;
        wc = '0; cs = '0;
        mon_on = 1'b1;

        @(posedge clk); #1;
        num_words   = 16'(words);
        num_iters   = 8'(iters);
        bubble_en   = bub;
        bubble_seed = seed;
        in_tready   = 1'b1;
        start       = 1'b1;
        run_start   = cyc;
        for (int rel = 1; rel < 5000; rel++) begin
            @(posedge clk); #1;
            start = 1'b0;
            case (ready_mode)
                1:       in_tready = !(rel >= 3 && rel <= 5);
                2:       in_tready = ($urandom_range(3) != 0);
                default: in_tready = 1'b1;
            endcase
            out_tvalid = 1'b0;
            out_tlast  = 1'b0;
            out_tdata  = '0;
            pk = (rel - 4) / 5;
            ph = (rel - 4) % 5;
            if (rel >= 4 && pk < npk && ph < 3) begin
                if (pk == 0) w = 64'(ph + 1);
                else         w = {$urandom, $urandom};
                out_tvalid = 1'b1;
                out_tdata  = w;
                wc = wc + 32'd1;
                cs = model_cs(cs, w);
                if (ph == 2) begin
                    out_tlast = 1'b1;
                    if (exp_icnt != 8'hFF) exp_icnt = exp_icnt + 8'd1;
                    exp_res_q.push_back('{words: wc, cs: cs, cnt: exp_icnt});
                    wc = '0;
                    cs = '0;
                end
            end
            if (done_cyc >= 0 && cyc > done_cyc + 3) break;
        end
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        @(negedge clk);
        mon_on = 1'b0;

        check_val({name, "_done_count"}, 64'(n_done), 64'd1);
        check_val({name, "_handshakes"}, 64'(n_hs), 64'(words * iters));
        check_val({name, "_reads"}, 64'(n_mem), 64'(words * iters));
        check_val({name, "_beats_left"}, 64'(exp_beat_q.size()), 64'd0);
        check_val({name, "_results_left"}, 64'(exp_res_q.size()), 64'd0);
        check_val({name, "_iter_done_count"}, 64'(n_iterdone), 64'(npk));
        check_val({name, "_final_iter_count"}, 64'(iter_count), 64'(exp_icnt));
        check_val({name, "_busy_after"}, 64'(busy), 64'd0);
        if (words * iters == 0) begin
            check_val({name, "_done_latency"}, 64'(done_cyc - run_start), 64'd2);
            check_val({name, "_no_valid"}, 64'(first_valid), 64'(-1));
            check_val({name, "_res_words_zero"}, 64'(res_words), 64'd0);
            check_val({name, "_res_cs_zero"}, 64'(res_checksum), 64'd0);
        end else if (!bub) begin
            check_val({name, "_first_valid"}, 64'(first_valid - run_start), 64'd3);
        end else begin
            check_val({name, "_first_valid_min"}, 64'((first_valid - run_start) >= 3), 64'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_iter_done", 64'(iter_done), 64'd0);
        check_val("rst_in_tvalid", 64'(in_tvalid), 64'd0);
        check_val("rst_mem_en", 64'(mem_en), 64'd0);
        check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_val("rst_in_tdata", 64'(in_tdata), 64'd0);
        check_val("rst_iter_count", 64'(iter_count), 64'd0);
        check_val("rst_res_words", 64'(res_words), 64'd0);
        check_val("rst_res_checksum", 64'(res_checksum), 64'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;

        run_case("basic", 8, 1, 1'b0, 16'h0000, 0, 1);

        // Output words while idle must not disturb the results.
        mon_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            out_tvalid = 1'b1;
            out_tlast  = 1'b1;
            out_tdata  = 64'hDEAD_BEEF_0000_0001;
        end
        @(posedge clk); #1;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        @(negedge clk);
        mon_on = 1'b0;
        check_val("idle_res_words", 64'(res_words), 64'd3);
        check_val("idle_res_checksum", 64'(res_checksum), 64'd3);
        check_val("idle_iter_count", 64'(iter_count), 64'd1);

        run_case("stall", 8, 1, 1'b0, 16'h0000, 1, 2);
        run_case("bubble", 64, 2, 1'b1, 16'hACE1, 0, 2);
        run_case("random", 20, 3, 1'b1, 16'h0000, 2, 3);
        run_case("zero_iters", 8, 0, 1'b0, 16'h0000, 0, 0);
        run_case("zero_words", 0, 2, 1'b0, 16'h0000, 0, 0);

        // Abort mid-stream with reset.
        @(posedge clk); #1;
        num_words = 16'd32;
        num_iters = 8'd1;
        bubble_en = 1'b0;
        in_tready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("abort_busy_before", 64'(busy), 64'd1);
        aresetn = 1'b0;
        @(negedge clk);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_in_tvalid", 64'(in_tvalid), 64'd0);
        check_val("abort_in_tdata", 64'(in_tdata), 64'd0);
        check_val("abort_mem_en", 64'(mem_en), 64'd0);
        check_val("abort_mem_addr", 64'(mem_addr), 64'd0);
        check_val("abort_done", 64'(done), 64'd0);
        check_val("abort_iter_count", 64'(iter_count), 64'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;

        run_case("post_abort", 8, 1, 1'b0, 16'h0000, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
